// File: rtl/multiword_add_ctrl.sv
// Multiword adder/subtractor that time-shares one N-bit adder across WORDS words,
// processing the least-significant word first.

// Plain ripple N-bit adder with carry in and carry out.
module adder_nbit #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

module multiword_add_ctrl #(
   parameter int unsigned N     = 4,
   parameter int unsigned WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 op_sub,
   input  logic [N*WORDS-1:0]   a,
   input  logic [N*WORDS-1:0]   b,
   output logic                 busy,
   output logic                 done,
   output logic [N*WORDS-1:0]   result,
   output logic                 cout,
   output logic                 ovf
);

   localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

   state_e               state_q, state_d;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic                 carry_q, carry_d;
   logic                 sub_q, sub_d;
   logic [N*WORDS-1:0]   a_q, a_d;
   logic [N*WORDS-1:0]   b_q, b_d;
   logic [N*WORDS-1:0]   result_q, result_d;
   logic                 cout_q, cout_d;
   logic                 ovf_q, ovf_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic [N-1:0]         add_a, add_b, add_sum;
   logic                 add_cout;

   // Select the current word; subtraction is a + ~b + 1 with the +1 seeded in carry_q.
   always_comb begin
      add_a = a_q[idx_q*N +: N];
      add_b = b_q[idx_q*N +: N] ^ {N{sub_q}};
   end

   adder_nbit #(
      .N (N)
   ) u_adder (
      .a    (add_a),
      .b    (add_b),
      .cin  (carry_q),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Next-state and registered-output logic for the IDLE/ADD/DONE sequencer.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      sub_d    = sub_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               sub_d   = op_sub;
               idx_d   = '0;
               carry_d = op_sub;
               state_d = StAdd;
            end
         end
         StAdd: begin
            result_d[idx_q*N +: N] = add_sum;
            carry_d = add_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IdxW'(WORDS - 1)) begin
               // Top word: its carry and sign bits define the whole-operand flags.
               state_d = StDone;
               idx_d   = '0;
               cout_d  = add_cout;
               ovf_d   = (add_a[N-1] == add_b[N-1]) && (add_sum[N-1] != add_a[N-1]);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      busy_d = (state_d == StAdd);
      done_d = (state_d == StDone);
   end

   // All state, including the registered busy/done flags, with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         sub_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         sub_q    <= sub_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign cout   = cout_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Bench for multiword_add_ctrl (N=4, WORDS=4): directed cases plus random ops
// against an arithmetic reference model.
module tb_multiword_add_ctrl;

   localparam int unsigned N     = 4;
   localparam int unsigned WORDS = 4;
   localparam int unsigned W     = N * WORDS;

   logic         clk;
   logic         rst;
   logic         start;
   logic         op_sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;

   int checks   = 0;
   int failures = 0;

   multiword_add_ctrl #(
      .N     (N),
      .WORDS (WORDS)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op_sub (op_sub),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Whole-width modular arithmetic with unsigned carry/no-borrow and signed overflow.
   function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic sub, output logic [W-1:0] r,
                                 output logic c, output logic o);
      logic [W:0] s;
      if (sub) begin
         r = x - y;
         c = (x >= y);
         o = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end else begin
         s = {1'b0, x} + {1'b0, y};
         r = s[W-1:0];
         c = s[W];
         o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
   endfunction

   // One operation: start accepted at edge k, then sample #1 after edges k..k+WORDS+1.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sub,
                         input bit keep, input bit intrude);
      logic [W-1:0] er;
      logic         ec, eo;
      model(av, bv, sub, er, ec, eo);
      @(negedge clk);
      start  = 1'b1;
      a      = av;
      b      = bv;
      op_sub = sub;
      @(posedge clk);
      #1;
      if (!keep) begin
         start  = 1'b0;
         a      = W'($urandom);
         b      = W'($urandom);
         op_sub = 1'($urandom);
      end
      for (int j = 0; j <= int'(WORDS) + 1; j++) begin
         if (j > 0) begin
            @(posedge clk);
            #1;
         end
         chk("busy", busy, (j < int'(WORDS)));
         chk("done", done, (j == int'(WORDS)));
         if (j >= int'(WORDS)) begin
            chk("result", result, er);
            chk("cout", cout, ec);
            chk("ovf", ovf, eo);
         end
         if (intrude && j == 1) begin
            start  = 1'b1;
            a      = '1;
            b      = '1;
            op_sub = 1'b0;
         end
         if (intrude && j == 2) start = 1'b0;
      end
   endtask

   initial begin
      logic [W-1:0] held;
      logic [W-1:0] ra, rb;
      rst    = 1'b1;
      start  = 1'b0;
      op_sub = 1'b0;
      a      = '0;
      b      = '0;
      #3;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_result", result, 16'h0000);
      chk("rst_cout", cout, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Directed arithmetic cases.
      run_op(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
      run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0);
      run_op(16'h0007, 16'h0005, 1'b1, 1'b0, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);

      // Idle with start low holds the outputs.
      held = result;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_hold_result", result, held);
      chk("idle_hold_busy", busy, 1'b0);

      // Start pulsed during ADD must be ignored.
      run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("intrude_no_restart", busy, 1'b0);
      chk("intrude_result", result, 16'h2345);

      // Start held high: re-accepted on the IDLE cycle after DONE.
      run_op(16'h0100, 16'h0023, 1'b0, 1'b1, 1'b0);
      run_op(16'h0100, 16'h0023, 1'b0, 1'b0, 1'b0);

      // Reset during the third ADD cycle abandons the op.
      @(negedge clk);
      start  = 1'b1;
      a      = 16'h4321;
      b      = 16'h1111;
      op_sub = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_result", result, 16'h0000);
      chk("midrst_cout", cout, 1'b0);
      chk("midrst_ovf", ovf, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk("midrst_no_done", done, 1'b0);
      end
      rst = 1'b0;
      run_op(16'h4321, 16'h1111, 1'b0, 1'b0, 1'b0);

      // Random operations.
      for (int i = 0; i < 24; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         run_op(ra, rb, 1'($urandom), 1'b0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
